// File: rtl/dsp19x2_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsp19x2_sched_pkg
// Brief    : Shared widths and the in-flight tag type for the DSP19x2
//            round-robin scheduler.
// Revision : 1.0  initial release
// ============================================================================
package dsp19x2_sched_pkg;

    localparam int A_W     = 20;
    localparam int B_W     = 18;
    localparam int Z_W     = 38;
    localparam int SHIFT_W = 5;
    localparam int CNT_W   = 16;
    localparam int ID_W    = 3;

    // One in-flight operation: valid flag plus the requester it returns to
    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/dsp19x2_rr_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : N-way round-robin arbiter. Combinational one-hot grant; the
//            search starts at the pointer, and the pointer moves to the slot
//            after the winner whenever a grant is issued.
// Revision : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic [2:0]   gnt_id
);

    localparam int c_PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic [N-1:0]       w_rot;
    logic               w_found;
    int                 w_win;
    int                 w_next;

    // Rotate requests so bit 0 is the pointer slot, pick the first set bit,
    // then map the winner back to its absolute index
    always_comb begin
        w_rot   = en ? N'({req, req} >> r_ptr) : '0;
        w_found = 1'b0;
        w_win   = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_win   = int'(r_ptr) + k;
            end
        end
        if (w_win >= N) begin
            w_win = w_win - N;
        end
        w_next = w_win + 1;
        if (w_next >= N) begin
            w_next = 0;
        end
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = w_found && (w_win == i);
        end
        gnt_id = 3'(w_win);
    end

    // Pointer advances past the winner; holds when nothing is granted
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= c_PTR_W'(w_next);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dsp19x2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dsp19x2_rr_scheduler
// Brief    : Shares one registered-input DSP19x2 among NREQ requesters with
//            round-robin valid/ready arbitration, per-requester shift config
//            and in-order tagged return of the 38-bit result.
//            Optional macro DSP_SCHED_PERF_CNT_EN adds per-requester
//            saturating grant counters on port grant_cnt.
// Revision : 1.0  initial release
// ============================================================================
module dsp19x2_rr_scheduler
    import dsp19x2_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int DSP_LAT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sched_en,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_sel,
    input  logic [SHIFT_W-1:0]    cfg_shift,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*A_W-1:0]   req_a,
    input  logic [NREQ*B_W-1:0]   req_b,
    output logic [A_W-1:0]        dsp_a,
    output logic [B_W-1:0]        dsp_b,
    output logic [SHIFT_W-1:0]    dsp_acc_fir,
    input  logic [Z_W-1:0]        dsp_z,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [Z_W-1:0]        rsp_data,
`ifdef DSP_SCHED_PERF_CNT_EN
    output logic [NREQ*CNT_W-1:0] grant_cnt,
`endif
    output logic                  busy
);

    logic [NREQ-1:0]    w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic               w_accept;
    logic               w_arb_en;
    logic [A_W-1:0]     w_sel_a;
    logic [B_W-1:0]     w_sel_b;
    logic [SHIFT_W-1:0] w_sel_shift;
    logic               w_busy;

    logic [SHIFT_W-1:0] r_shift [NREQ];
    logic [A_W-1:0]     r_dsp_a;
    logic [B_W-1:0]     r_dsp_b;
    logic [SHIFT_W-1:0] r_dsp_acc_fir;
    tag_t               r_tag [DSP_LAT+1];
    logic [NREQ-1:0]    r_rsp_valid;
    logic [Z_W-1:0]     r_rsp_data;

    // Grants are suppressed while reset is held so req_ready reads 0
    assign w_arb_en = sched_en & reset;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .en     (w_arb_en),
        .req    (req_valid),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    assign req_ready = w_gnt;
    assign w_accept  = |w_gnt;

    // One-hot operand mux; all-zero when nothing is granted
    always_comb begin
        w_sel_a     = '0;
        w_sel_b     = '0;
        w_sel_shift = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt[i]) begin
                w_sel_a     = w_sel_a     | req_a[A_W*i +: A_W];
                w_sel_b     = w_sel_b     | req_b[B_W*i +: B_W];
                w_sel_shift = w_sel_shift | r_shift[i];
            end
        end
    end

    // Shift config; the loop bound makes selections >= NREQ match nothing
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREQ; i++) begin
                r_shift[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (cfg_we && (cfg_sel == 3'(i))) begin
                    r_shift[i] <= cfg_shift;
                end
            end
        end
    end

    // DSP input stage: grantee operands, zeros on idle cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dsp_a       <= '0;
            r_dsp_b       <= '0;
            r_dsp_acc_fir <= '0;
        end else begin
            r_dsp_a       <= w_sel_a;
            r_dsp_b       <= w_sel_b;
            r_dsp_acc_fir <= w_sel_shift;
        end
    end

    assign dsp_a       = r_dsp_a;
    assign dsp_b       = r_dsp_b;
    assign dsp_acc_fir = r_dsp_acc_fir;

    // Tag pipe: last stage lines up with dsp_z of the same operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= DSP_LAT; k++) begin
                r_tag[k] <= '{vld: 1'b0, id: '0};
            end
        end else begin
            r_tag[0] <= '{vld: w_accept, id: w_gnt_id};
            for (int k = 1; k <= DSP_LAT; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    // Response stage: decode tag to one-hot strobe; data holds when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                r_rsp_valid[i] <= r_tag[DSP_LAT].vld && (r_tag[DSP_LAT].id == 3'(i));
            end
            if (r_tag[DSP_LAT].vld) begin
                r_rsp_data <= dsp_z;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;

    // Busy while any tag or response strobe is live
    always_comb begin
        w_busy = |r_rsp_valid;
        for (int k = 0; k <= DSP_LAT; k++) begin
            w_busy = w_busy | r_tag[k].vld;
        end
    end

    assign busy = w_busy;

`ifdef DSP_SCHED_PERF_CNT_EN
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_perf_cnt
            logic [CNT_W-1:0] r_cnt;

            // Saturating accept counter, cleared by a config write to this slot
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (cfg_we && (cfg_sel == 3'(g))) begin
                    r_cnt <= '0;
                end else if (w_gnt[g] && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign grant_cnt[CNT_W*g +: CNT_W] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_dsp19x2_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsp19x2_rr_scheduler
// Brief    : Directed bench for dsp19x2_rr_scheduler with a behavioural
//            registered-input DSP19x2 model and an in-order response queue.
//            Define DSP_SCHED_PERF_CNT_EN to also exercise grant_cnt.
// Revision : 1.0  initial release
// ============================================================================
module tb_dsp19x2_rr_scheduler;

    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sched_en;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [4:0]  cfg_shift;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [79:0] req_a;
    logic [71:0] req_b;
    logic [19:0] dsp_a;
    logic [17:0] dsp_b;
    logic [4:0]  dsp_acc_fir;
    logic [37:0] dsp_z;
    logic [3:0]  rsp_valid;
    logic [37:0] rsp_data;
    logic        busy;
`ifdef DSP_SCHED_PERF_CNT_EN
    logic [63:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [19:0] op_a  [NREQ];
    logic [17:0] op_b  [NREQ];
    logic [4:0]  sh_md [NREQ];

    typedef struct {
        int          id;
        logic [37:0] z;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0] valid;
        logic       en;
        logic [3:0] exp_rdy;
    } vec_t;
    vec_t vecs [16];

    dsp19x2_rr_scheduler #(.NREQ(NREQ), .DSP_LAT(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .sched_en    (sched_en),
        .cfg_we      (cfg_we),
        .cfg_sel     (cfg_sel),
        .cfg_shift   (cfg_shift),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .dsp_a       (dsp_a),
        .dsp_b       (dsp_b),
        .dsp_acc_fir (dsp_acc_fir),
        .dsp_z       (dsp_z),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
`ifdef DSP_SCHED_PERF_CNT_EN
        .grant_cnt   (grant_cnt),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [37:0] dsp_model(input logic [19:0] a, input logic [17:0] b,
                                              input logic [4:0] sh);
        logic [18:0] l0;
        logic [18:0] l1;
        l0 = (19'(a[9:0]) << sh) + 19'(b[8:0]);
        l1 = 19'(a[19:10]) << sh;
        return {l1, l0};
    endfunction

    // Registered-input DSP: result one cycle after operands are driven
    always @(posedge clk) dsp_z <= dsp_model(dsp_a, dsp_b, dsp_acc_fir);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_a[20*i +: 20] = op_a[i];
            req_b[18*i +: 18] = op_b[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Response monitor: every strobe must match the queue head on its due cycle
    always begin
        @(posedge clk);
        #2;
        if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            check("rsp_missing", 64'(exp_q[0].due), 64'(cyc));
            void'(exp_q.pop_front());
        end
        if (rsp_valid != 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
                check("rsp_id",   64'(rsp_valid), 64'(4'b0001 << exp_q[0].id));
                check("rsp_data", 64'(rsp_data),  64'(exp_q[0].z));
                check("rsp_time", 64'(cyc),       64'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
        end
    end

    // Entered at posedge+1; drives one cycle, checks req_ready, queues the result
    task automatic apply(input logic [3:0] v, input logic en, input logic [3:0] exp_rdy);
        req_valid = v;
        sched_en  = en;
        #1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        for (int i = 0; i < NREQ; i++) begin
            if (exp_rdy[i]) begin
                exp_q.push_back('{id: i, z: dsp_model(op_a[i], op_b[i], sh_md[i]), due: cyc + 3});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < NREQ; i++) sh_md[i] = '0;
    endtask

    task automatic write_shift(input int sel, input logic [4:0] sh);
        cfg_we    = 1'b1;
        cfg_sel   = 3'(sel);
        cfg_shift = sh;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        if (sel < NREQ) sh_md[sel] = sh;
    endtask

    initial begin
        reset     = 1'b0;
        sched_en  = 1'b1;
        cfg_we    = 1'b0;
        cfg_sel   = '0;
        cfg_shift = '0;
        req_valid = 4'hF;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i]  = {10'(i + 1), 10'(3 * i + 5)};
            op_b[i]  = 18'(7 * i + 1);
            sh_md[i] = '0;
        end

        // Reset state with every requester asking
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 64'(req_ready),   64'(0));
        check("rst_rsp",   64'(rsp_valid),   64'(0));
        check("rst_data",  64'(rsp_data),    64'(0));
        check("rst_dsp_a", 64'(dsp_a),       64'(0));
        check("rst_dsp_b", 64'(dsp_b),       64'(0));
        check("rst_acc",   64'(dsp_acc_fir), 64'(0));
        check("rst_busy",  64'(busy),        64'(0));
        req_valid = '0;
        reset     = 1'b1;

        // Single op with shift 2, then cfg write racing a grant
        write_shift(0, 5'd2);
        op_a[0] = 20'd255;
        op_b[0] = 18'd1;
        apply(4'b0001, 1'b1, 4'b0001);
        check("dsp_a_t1", 64'(dsp_a),       64'(255));
        check("dsp_b_t1", 64'(dsp_b),       64'(1));
        check("acc_t1",   64'(dsp_acc_fir), 64'(2));
        cfg_we = 1'b1; cfg_sel = 3'd0; cfg_shift = 5'd3;
        apply(4'b0001, 1'b1, 4'b0001);
        cfg_we = 1'b0; sh_md[0] = 5'd3;
        apply(4'b0001, 1'b1, 4'b0001);
        check("lat_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("lat_rsp_data",  64'(rsp_data),  64'(1021));
        apply(4'b0000, 1'b1, 4'b0000);
        apply(4'b0000, 1'b1, 4'b0000);
        check("busy_last", 64'(busy), 64'(1));
        apply(4'b0000, 1'b1, 4'b0000);
        check("busy_fall", 64'(busy),     64'(0));
        check("data_hold", 64'(rsp_data), 64'(2041));

        // Arbitration table from a fresh pointer
        do_reset();
        write_shift(0, 5'd2);
        write_shift(1, 5'd1);
        write_shift(3, 5'd3);
        write_shift(6, 5'd7);
        vecs[0]  = '{4'hF,    1'b1, 4'b0001};
        vecs[1]  = '{4'hF,    1'b1, 4'b0010};
        vecs[2]  = '{4'hF,    1'b1, 4'b0100};
        vecs[3]  = '{4'hF,    1'b1, 4'b1000};
        vecs[4]  = '{4'hF,    1'b1, 4'b0001};
        vecs[5]  = '{4'hF,    1'b1, 4'b0010};
        vecs[6]  = '{4'hF,    1'b1, 4'b0100};
        vecs[7]  = '{4'hF,    1'b1, 4'b1000};
        vecs[8]  = '{4'b0100, 1'b1, 4'b0100};
        vecs[9]  = '{4'b0011, 1'b1, 4'b0001};
        vecs[10] = '{4'b0011, 1'b1, 4'b0010};
        vecs[11] = '{4'hF,    1'b0, 4'b0000};
        vecs[12] = '{4'b0000, 1'b1, 4'b0000};
        vecs[13] = '{4'b1001, 1'b1, 4'b1000};
        vecs[14] = '{4'b0110, 1'b1, 4'b0010};
        vecs[15] = '{4'b0110, 1'b1, 4'b0100};
        for (int n = 0; n < 16; n++) begin
            apply(vecs[n].valid, vecs[n].en, vecs[n].exp_rdy);
        end
        repeat (5) apply(4'b0000, 1'b1, 4'b0000);

        // Scheduler disabled with three ops in flight
        do_reset();
        apply(4'b0111, 1'b1, 4'b0001);
        apply(4'b0111, 1'b1, 4'b0010);
        apply(4'b0111, 1'b1, 4'b0100);
        check("dis_busy", 64'(busy), 64'(1));
        apply(4'hF, 1'b0, 4'b0000);
        apply(4'hF, 1'b0, 4'b0000);
        check("dis_last_rsp", 64'(rsp_valid), 64'(4'b0100));
        check("dis_last_busy", 64'(busy), 64'(1));
        apply(4'hF, 1'b0, 4'b0000);
        check("dis_busy_fall", 64'(busy), 64'(0));

        // Reset with two ops in flight drops them
        do_reset();
        apply(4'b0011, 1'b1, 4'b0001);
        apply(4'b0011, 1'b1, 4'b0010);
        check("pre_rst_busy", 64'(busy), 64'(1));
        do_reset();
        for (int n = 0; n < 5; n++) begin
            check("post_rst_rsp",  64'(rsp_valid), 64'(0));
            check("post_rst_busy", 64'(busy),      64'(0));
            apply(4'b0000, 1'b1, 4'b0000);
        end

`ifdef DSP_SCHED_PERF_CNT_EN
        do_reset();
        for (int n = 0; n < 70000; n++) begin
            apply(4'b0010, 1'b1, 4'b0010);
        end
        repeat (4) apply(4'b0000, 1'b1, 4'b0000);
        check("cnt_sat",  64'(grant_cnt[31:16]), 64'(16'hFFFF));
        check("cnt_idle", 64'(grant_cnt[15:0]),  64'(0));
        write_shift(1, 5'd0);
        check("cnt_clr",  64'(grant_cnt[31:16]), 64'(0));
`endif

        repeat (3) apply(4'b0000, 1'b1, 4'b0000);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
